// File: rtl/mem_stage.sv
// Purpose: MEM pipeline stage. Consumes EX/MEM, runs one word load/store on the shared bus, checks alignment, drives MEM/WB.
// Latency: non-memory ops pass to MEM/WB on the next unstalled edge; a bus access takes at least 3 cycles (IDLE->REQ->ACCESS->ready).
// Backpressure: mem_busy is raised while an access is outstanding; MEM/WB holds whenever stall is high (stall includes mem_busy).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   stall, flush        pipeline controller inputs (hold / clear MEM/WB)
//   ex_*                EX/MEM register outputs (ex_out carries the byte address for loads/stores)
//   mem_busy            combinational stall request to the controller
//   bus_*               shared bus master side (active-low req/as/rdy/grant)
//   mem_*               MEM/WB register outputs

module mem_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    // EX/MEM register
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_en,
    input  logic              ex_br_flag,
    input  logic [1:0]        ex_mem_op,
    input  logic [DATA_W-1:0] ex_mem_wr_data,
    input  logic [1:0]        ex_ctrl_op,
    input  logic [REG_W-1:0]  ex_dst_addr,
    input  logic              ex_gpr_we_,
    input  logic [2:0]        ex_exp_code,
    input  logic [DATA_W-1:0] ex_out,
    // Stall request
    output logic              mem_busy,
    // Shared bus master
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    // MEM/WB register
    output logic [ADDR_W-1:0] mem_pc,
    output logic              mem_en,
    output logic              mem_br_flag,
    output logic [1:0]        mem_ctrl_op,
    output logic [REG_W-1:0]  mem_dst_addr,
    output logic              mem_gpr_we_,
    output logic [2:0]        mem_exp_code,
    output logic [DATA_W-1:0] mem_out
);

    // Bus access state machine
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Memory op encoding (0 and 3 are both NOP)
    localparam logic [1:0] OP_LDW = 2'd1;
    localparam logic [1:0] OP_STW = 2'd2;

    localparam logic [2:0] EXP_NONE     = 3'd0;
    localparam logic [2:0] EXP_MISALIGN = 3'd4;

    logic [1:0]        state;
    logic [DATA_W-1:0] rd_buf;
    logic [DATA_W-1:0] rd_data;

    logic valid;
    logic misalign;
    logic is_ldst;
    logic is_ldw;
    logic acc;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign valid    = ex_en && (ex_exp_code == EXP_NONE);
    assign misalign = (ex_out[1:0] != 2'b00);
    assign is_ldw   = (ex_mem_op == OP_LDW);
    assign is_ldst  = is_ldw || (ex_mem_op == OP_STW);
    assign acc      = valid && is_ldst && !misalign;

    // Read data is taken straight off the bus in the ready cycle so a
    // non-stalled pipeline can write MEM/WB without an extra cycle; once
    // the access has finished, the captured copy is used instead.
    assign rd_data = (state == ST_ACCESS) ? bus_rd_data : rd_buf;

    // ------------------------------------------------------------------
    // Stall request. Drops in the ready cycle so MEM/WB captures the
    // load result on that same edge.
    // ------------------------------------------------------------------
    always_comb begin
        mem_busy = 1'b0;
        case (state)
            ST_IDLE:   mem_busy = acc && !flush;
            ST_REQ:    mem_busy = 1'b1;
            ST_ACCESS: mem_busy = bus_rdy_;
            default:   mem_busy = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus FSM. All bus outputs are registered and change on the edge
    // that enters the corresponding state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rd_buf      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acc && !flush) begin
                        state    <= ST_REQ;
                        bus_req_ <= 1'b0;
                    end
                end
                // Flush is deliberately not looked at once the request is
                // out: the bus transaction must run to completion.
                ST_REQ: begin
                    if (!bus_grnt_) begin
                        state    <= ST_ACCESS;
                        bus_as_  <= 1'b0;
                        bus_addr <= ex_out[ADDR_W+1:2];
                        bus_rw   <= is_ldw;
                        if (ex_mem_op == OP_STW) begin
                            bus_wr_data <= ex_mem_wr_data;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Address strobe is a single-cycle pulse.
                    bus_as_ <= 1'b1;
                    if (!bus_rdy_) begin
                        rd_buf   <= bus_rd_data;
                        bus_req_ <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The completed entry is still sitting in EX/MEM while
                    // the pipeline is stalled; waiting here keeps it from
                    // being issued a second time.
                    if (!stall) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_pc       <= '0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= '0;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= EXP_NONE;
            mem_out      <= '0;
        end else if (!stall) begin
            if (flush) begin
                mem_pc       <= '0;
                mem_en       <= 1'b0;
                mem_br_flag  <= 1'b0;
                mem_ctrl_op  <= '0;
                mem_dst_addr <= '0;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= EXP_NONE;
                mem_out      <= '0;
            end else if (valid && is_ldst && misalign) begin
                // Misaligned access becomes an exception: keep the pc and
                // flags for the handler, suppress any register side effect.
                mem_pc       <= ex_pc;
                mem_en       <= ex_en;
                mem_br_flag  <= ex_br_flag;
                mem_ctrl_op  <= '0;
                mem_dst_addr <= '0;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= EXP_MISALIGN;
                mem_out      <= '0;
            end else begin
                mem_pc       <= ex_pc;
                mem_en       <= ex_en;
                mem_br_flag  <= ex_br_flag;
                mem_ctrl_op  <= ex_ctrl_op;
                mem_dst_addr <= ex_dst_addr;
                mem_gpr_we_  <= ex_gpr_we_;
                mem_exp_code <= ex_exp_code;
                mem_out      <= (is_ldw && valid) ? rd_data : ex_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;
    localparam int REG_W  = 5;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              ext_stall;
    logic              flush;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_en;
    logic              ex_br_flag;
    logic [1:0]        ex_mem_op;
    logic [DATA_W-1:0] ex_mem_wr_data;
    logic [1:0]        ex_ctrl_op;
    logic [REG_W-1:0]  ex_dst_addr;
    logic              ex_gpr_we_;
    logic [2:0]        ex_exp_code;
    logic [DATA_W-1:0] ex_out;
    logic              mem_busy;
    logic              bus_req_;
    logic              bus_grnt_;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;
    logic [ADDR_W-1:0] mem_pc;
    logic              mem_en;
    logic              mem_br_flag;
    logic [1:0]        mem_ctrl_op;
    logic [REG_W-1:0]  mem_dst_addr;
    logic              mem_gpr_we_;
    logic [2:0]        mem_exp_code;
    logic [DATA_W-1:0] mem_out;

    int checks = 0;
    int errors = 0;
    int busy_cnt;

    // Pipeline controller: global stall is the external request OR'd with ours.
    assign stall = ext_stall | mem_busy;

    mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag),
        .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data),
        .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .mem_busy(mem_busy),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
        .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
        .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
        .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code), .mem_out(mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic              en;
        logic [2:0]        exp_c;
        logic [1:0]        op;
        logic [DATA_W-1:0] out;
        logic              we_;
        logic [REG_W-1:0]  dst;
        logic [1:0]        ctrl;
        logic              br;
        logic [ADDR_W-1:0] pc;
        logic              fl;
        logic              e_en;
        logic [2:0]        e_exp;
        logic [DATA_W-1:0] e_out;
        logic              e_we_;
        logic [REG_W-1:0]  e_dst;
        logic [1:0]        e_ctrl;
        logic              e_br;
        logic [ADDR_W-1:0] e_pc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop_in();
        ex_en = 1'b0; ex_mem_op = 2'd0; ex_out = 32'h55; ex_exp_code = 3'd0;
        ex_gpr_we_ = 1'b1; ex_dst_addr = '0; ex_ctrl_op = 2'd0; ex_pc = '0;
        ex_br_flag = 1'b0; ex_mem_wr_data = '0; flush = 1'b0;
    endtask

    task automatic ldst(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic we_, input logic [4:0] dst, input logic [29:0] pc);
        nop_in();
        ex_en = 1'b1; ex_mem_op = op; ex_out = addr; ex_mem_wr_data = wd;
        ex_gpr_we_ = we_; ex_dst_addr = dst; ex_pc = pc;
    endtask

    initial begin
        // en exp op out we_ dst ctrl br pc flush | e_en e_exp e_out e_we_ e_dst e_ctrl e_br e_pc
        vecs[0] = '{1'b1, 3'd0, 2'd0, 32'h0000_1234, 1'b0, 5'd3, 2'd1, 1'b0, 30'h10, 1'b0,
                    1'b1, 3'd0, 32'h0000_1234, 1'b0, 5'd3, 2'd1, 1'b0, 30'h10};
        vecs[1] = '{1'b1, 3'd0, 2'd3, 32'hABCD_0001, 1'b0, 5'd9, 2'd2, 1'b1, 30'h11, 1'b0,
                    1'b1, 3'd0, 32'hABCD_0001, 1'b0, 5'd9, 2'd2, 1'b1, 30'h11};
        vecs[2] = '{1'b1, 3'd0, 2'd1, 32'h0000_0102, 1'b0, 5'd4, 2'd3, 1'b1, 30'h12, 1'b0,
                    1'b1, 3'd4, 32'h0000_0000, 1'b1, 5'd0, 2'd0, 1'b1, 30'h12};
        vecs[3] = '{1'b1, 3'd0, 2'd2, 32'h0000_0003, 1'b1, 5'd5, 2'd1, 1'b0, 30'h13, 1'b0,
                    1'b1, 3'd4, 32'h0000_0000, 1'b1, 5'd0, 2'd0, 1'b0, 30'h13};
        vecs[4] = '{1'b0, 3'd0, 2'd1, 32'h0000_0100, 1'b0, 5'd6, 2'd2, 1'b0, 30'h14, 1'b0,
                    1'b0, 3'd0, 32'h0000_0100, 1'b0, 5'd6, 2'd2, 1'b0, 30'h14};
        vecs[5] = '{1'b1, 3'd2, 2'd1, 32'h0000_0102, 1'b0, 5'd7, 2'd0, 1'b0, 30'h15, 1'b0,
                    1'b1, 3'd2, 32'h0000_0102, 1'b0, 5'd7, 2'd0, 1'b0, 30'h15};
        vecs[6] = '{1'b1, 3'd0, 2'd1, 32'h0000_0300, 1'b0, 5'd8, 2'd1, 1'b1, 30'h16, 1'b1,
                    1'b0, 3'd0, 32'h0000_0000, 1'b1, 5'd0, 2'd0, 1'b0, 30'h0};

        // ---------------- reset state ----------------
        reset = 1'b1; ext_stall = 1'b0; nop_in();
        bus_grnt_ = 1'b0; bus_rdy_ = 1'b1; bus_rd_data = '0;
        tick(); tick();
        chk("rst_req", bus_req_, 1'b1);
        chk("rst_as", bus_as_, 1'b1);
        chk("rst_rw", bus_rw, 1'b1);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wr_data, 0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_gpr_we_, 1'b1);
        chk("rst_mem_out", mem_out, 0);
        chk("rst_mem_pc", mem_pc, 0);
        chk("rst_busy", mem_busy, 1'b0);
        reset = 1'b0;

        // ---------------- table: no-bus-activity cases ----------------
        for (int i = 0; i < 7; i++) begin
            nop_in();
            ex_en = vecs[i].en; ex_exp_code = vecs[i].exp_c; ex_mem_op = vecs[i].op;
            ex_out = vecs[i].out; ex_gpr_we_ = vecs[i].we_; ex_dst_addr = vecs[i].dst;
            ex_ctrl_op = vecs[i].ctrl; ex_br_flag = vecs[i].br; ex_pc = vecs[i].pc;
            flush = vecs[i].fl;
            #1;
            chk($sformatf("v%0d_busy", i), mem_busy, 1'b0);
            tick();
            chk($sformatf("v%0d_req", i), bus_req_, 1'b1);
            chk($sformatf("v%0d_en", i), mem_en, vecs[i].e_en);
            chk($sformatf("v%0d_exp", i), mem_exp_code, vecs[i].e_exp);
            chk($sformatf("v%0d_out", i), mem_out, vecs[i].e_out);
            chk($sformatf("v%0d_we", i), mem_gpr_we_, vecs[i].e_we_);
            chk($sformatf("v%0d_dst", i), mem_dst_addr, vecs[i].e_dst);
            chk($sformatf("v%0d_ctrl", i), mem_ctrl_op, vecs[i].e_ctrl);
            chk($sformatf("v%0d_br", i), mem_br_flag, vecs[i].e_br);
            chk($sformatf("v%0d_pc", i), mem_pc, vecs[i].e_pc);
        end

        // ---------------- LDW, immediate grant, ready on 2nd ACCESS cycle ----------------
        ldst(2'd1, 32'h0000_0100, 32'h0, 1'b0, 5'd7, 30'h20);
        busy_cnt = 0;
        #1;
        chk("ld_busy_idle", mem_busy, 1'b1);
        busy_cnt += int'(mem_busy);
        tick();                                   // REQ
        chk("ld_req", bus_req_, 1'b0);
        chk("ld_as_req", bus_as_, 1'b1);
        busy_cnt += int'(mem_busy);
        tick();                                   // ACCESS #1
        chk("ld_as", bus_as_, 1'b0);
        chk("ld_addr", bus_addr, 30'h40);
        chk("ld_rw", bus_rw, 1'b1);
        busy_cnt += int'(mem_busy);
        tick();                                   // ACCESS #2
        chk("ld_as_pulse", bus_as_, 1'b1);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
        #1;
        busy_cnt += int'(mem_busy);
        chk("ld_busy_cnt", busy_cnt, 3);
        tick();                                   // DONE
        bus_rdy_ = 1'b1; bus_rd_data = '0; nop_in();
        chk("ld_mem_out", mem_out, 32'hDEAD_BEEF);
        chk("ld_mem_we", mem_gpr_we_, 1'b0);
        chk("ld_mem_en", mem_en, 1'b1);
        chk("ld_mem_dst", mem_dst_addr, 5'd7);
        chk("ld_mem_pc", mem_pc, 30'h20);
        chk("ld_req_done", bus_req_, 1'b1);
        tick();                                   // IDLE, MEM/WB takes the NOP

        // ---------------- STW, grant withheld 3 cycles ----------------
        ldst(2'd2, 32'h0000_0008, 32'h1234_5678, 1'b1, 5'd0, 30'h21);
        bus_grnt_ = 1'b1;
        tick();                                   // REQ
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("st_wait%0d_req", k), bus_req_, 1'b0);
            chk($sformatf("st_wait%0d_busy", k), mem_busy, 1'b1);
            chk($sformatf("st_wait%0d_as", k), bus_as_, 1'b1);
            tick();
        end
        bus_grnt_ = 1'b0;
        tick();                                   // ACCESS #1
        chk("st_as", bus_as_, 1'b0);
        chk("st_addr", bus_addr, 30'h2);
        chk("st_rw", bus_rw, 1'b0);
        chk("st_wdata", bus_wr_data, 32'h1234_5678);
        chk("st_req_acc", bus_req_, 1'b0);
        tick();                                   // ACCESS #2
        chk("st_as_pulse", bus_as_, 1'b1);
        chk("st_req_acc2", bus_req_, 1'b0);
        bus_rdy_ = 1'b0;
        tick();                                   // DONE
        bus_rdy_ = 1'b1; nop_in();
        chk("st_mem_out", mem_out, 32'h8);
        chk("st_mem_en", mem_en, 1'b1);
        chk("st_req_done", bus_req_, 1'b1);
        tick();

        // ---------------- load completing under external stall ----------------
        chk("stl_pre_out", mem_out, 32'h55);
        ldst(2'd1, 32'h0000_0200, 32'h0, 1'b0, 5'd9, 30'h22);
        tick();                                   // REQ
        tick();                                   // ACCESS
        bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFE_F00D; ext_stall = 1'b1;
        #1;
        chk("stl_busy_rdy", mem_busy, 1'b0);
        tick();                                   // DONE
        bus_rdy_ = 1'b1; bus_rd_data = 32'h1111_1111;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("stl%0d_hold", k), mem_out, 32'h55);
            chk($sformatf("stl%0d_req", k), bus_req_, 1'b1);
            chk($sformatf("stl%0d_busy", k), mem_busy, 1'b0);
            tick();
        end
        ext_stall = 1'b0;
        #1;
        chk("stl_busy_release", mem_busy, 1'b0);
        tick();
        nop_in();
        chk("stl_mem_out", mem_out, 32'hCAFE_F00D);
        chk("stl_mem_dst", mem_dst_addr, 5'd9);
        chk("stl_no_reissue", bus_req_, 1'b1);
        tick();

        // ---------------- flush during an outstanding access ----------------
        ldst(2'd1, 32'h0000_0400, 32'h0, 1'b0, 5'd10, 30'h30);
        tick();                                   // REQ
        flush = 1'b1;
        #1;
        chk("fl_busy_req", mem_busy, 1'b1);
        tick();                                   // ACCESS despite flush
        chk("fl_as", bus_as_, 1'b0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'h77;
        tick();                                   // DONE, MEM/WB cleared
        bus_rdy_ = 1'b1; nop_in();
        chk("fl_mem_en", mem_en, 1'b0);
        chk("fl_mem_we", mem_gpr_we_, 1'b1);
        chk("fl_mem_out", mem_out, 0);
        chk("fl_mem_dst", mem_dst_addr, 0);
        tick();

        // ---------------- reset mid-ACCESS ----------------
        ldst(2'd2, 32'h0000_0500, 32'hA5A5_A5A5, 1'b1, 5'd0, 30'h31);
        tick();                                   // REQ
        tick();                                   // ACCESS
        chk("rm_as", bus_as_, 1'b0);
        reset = 1'b1;
        tick();
        chk("rm_req", bus_req_, 1'b1);
        chk("rm_as_after", bus_as_, 1'b1);
        chk("rm_rw", bus_rw, 1'b1);
        chk("rm_addr", bus_addr, 0);
        chk("rm_wdata", bus_wr_data, 0);
        chk("rm_mem_en", mem_en, 1'b0);
        chk("rm_mem_we", mem_gpr_we_, 1'b1);
        chk("rm_mem_out", mem_out, 0);
        chk("rm_mem_pc", mem_pc, 0);
        reset = 1'b0;
        // Only IDLE moves straight to REQ on a new access.
        ldst(2'd1, 32'h0000_0600, 32'h0, 1'b0, 5'd1, 30'h32);
        tick();
        chk("rm_idle_to_req", bus_req_, 1'b0);
        reset = 1'b1; nop_in();
        tick();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the EX/MEM pipeline interface.
- Takes the EX/MEM register outputs, performs load/store accesses over the shared bus (bus master handshake with grant), and checks alignment.
- Drives the MEM/WB pipeline register.
- Raises a busy/stall request to the pipeline controller while a bus access is outstanding.

Parameters:
- DATA_W, 32, word data width.
- ADDR_W, 30, word address width (byte address = ADDR_W+2 bits).
- REG_W, 5, GPR address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  global stall from controller; includes mem_busy.
- flush  in  1  flush MEM/WB.
- ex_pc  in  ADDR_W  EX/MEM pc.
- ex_en  in  1  EX/MEM entry valid.
- ex_br_flag  in  1  branch flag.
- ex_mem_op  in  2  memory op: 0=NOP, 1=LDW, 2=STW, 3=NOP.
- ex_mem_wr_data  in  DATA_W  store data.
- ex_ctrl_op  in  2  control-register op.
- ex_dst_addr  in  REG_W  GPR write address.
- ex_gpr_we_  in  1  GPR write enable, active low.
- ex_exp_code  in  3  exception code; 0=none, 4=misaligned.
- ex_out  in  DATA_W  ALU result / byte address.
- mem_busy  out  1  stall request.
- bus_req_  out  1  bus request, active low.
- bus_grnt_  in  1  bus grant, active low.
- bus_addr  out  ADDR_W  word address.
- bus_as_  out  1  address strobe, active low.
- bus_rw  out  1  1=read, 0=write.
- bus_wr_data  out  DATA_W  write data.
- bus_rd_data  in  DATA_W  read data.
- bus_rdy_  in  1  slave ready, active low.
- mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out  out  (same widths as ex_*)  MEM/WB register.

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-access): FSM=IDLE; bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0; rd_buf=0. All mem_* outputs = 0, except mem_gpr_we_=1.
- Decode:
  - valid = ex_en && ex_exp_code==0.
  - misalign = ex_out[1:0]!=0.
  - acc = valid && !misalign && ex_mem_op in {LDW, STW}.
  - Misalignment is checked only for LDW/STW.
- FSM is registered; bus outputs are registered and change on the edge entering a state.
  - IDLE: if acc && !flush → REQ, bus_req_=0. Otherwise stay.
  - REQ: when bus_grnt_==0 → ACCESS; in the same edge set bus_as_=0, bus_addr=ex_out[31:2], bus_rw=(op==LDW), and bus_wr_data=ex_mem_wr_data for STW.
  - ACCESS: bus_as_ is held low for one cycle only (deasserted on the next edge). Wait for bus_rdy_==0. On ready: capture rd_buf=bus_rd_data, bus_req_=1 → DONE.
  - DONE: hold while stall==1 (prevents re-issue of the same ex_* entry); → IDLE when stall==0.
- mem_busy (combinational) = (IDLE && acc && !flush) || REQ || (ACCESS && bus_rdy_==1). It is 0 in the ready cycle, so a single access costs ≥3 cycles.
- rd_data = (ACCESS) ? bus_rd_data : rd_buf.
- MEM/WB register updates only when stall==0:
  - flush: clear as on reset.
  - misalign on LDW/STW with valid: pass pc/en/br_flag; mem_ctrl_op=0, mem_dst_addr=0, mem_gpr_we_=1, mem_exp_code=4, mem_out=0.
  - otherwise: pass all ex_* fields; mem_out = (LDW && valid) ? rd_data : ex_out.
- stall==1: MEM/WB holds all values.
- ex_en==0 or ex_exp_code!=0: no bus activity; fields pass through.
- Grant withheld indefinitely: remain in REQ, busy stays asserted.
- Flush during REQ/ACCESS: ignored until the access completes; the MEM/WB register then clears on the first non-stalled cycle with flush asserted.

Test Plan:
- LDW, ex_out=0x0000_0100, grant immediate, rdy on 2nd ACCESS cycle with rd_data=0xDEAD_BEEF:
  - bus_addr=0x40, bus_rw=1;
  - mem_busy high for 3 cycles;
  - mem_out=0xDEAD_BEEF, mem_gpr_we_ follows ex_gpr_we_.
- STW, ex_out=0x8, wr_data=0x1234_5678, grant delayed 3 cycles:
  - bus_req_ low throughout;
  - bus_as_ pulses 1 cycle with bus_addr=0x2, bus_rw=0, bus_wr_data=0x1234_5678;
  - mem_out=0x8.
- LDW with ex_out=0x102:
  - no bus_req_;
  - mem_exp_code=4, mem_gpr_we_=1, mem_out=0, mem_busy=0.
- Load completes while external stall held 2 extra cycles:
  - FSM stays in DONE; no second bus_req_;
  - MEM/WB is written with rd_buf value once stall drops.
- Flush with a pending LDW in IDLE:
  - no access issued;
  - MEM/WB cleared (mem_en=0, mem_gpr_we_=1).
- Reset asserted mid-ACCESS:
  - next edge: bus_req_=1, bus_as_=1, FSM IDLE;
  - all mem_* at reset values.
